debounce_bank: RTL and testbench

Parametrised multi-channel debouncer: the successor to the single-channel `debouncer`. It synchronises `CHANNELS` asynchronous inputs (push-buttons, switches) into the `clk` domain and filters contact bounce per channel with a stability counter driven by a shared prescaler tick. It also produces registered one-cycle rise/fall strobes so downstream logic (input register, interrupt/event latch) needs no edge detector of its own.

---
 rtl/debounce_pkg.sv | 13 +
 rtl/debounce_channel.sv | 71 +++++++
 rtl/debounce_bank.sv | 75 +++++++
 tb/tb_debounce_bank.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
`timescale 1ns/100ps
// debounce_pkg: shared constants and helpers for the multi-channel debouncer.
package debounce_pkg;

  // Upper bound on the number of channels a single bank may carry.
  localparam int MAX_CHANNELS = 32;

  // Width of a stability counter able to hold 0..stable_ticks.
  function automatic int cnt_width(input int stable_ticks);
    return $clog2(stable_ticks + 1);
  endfunction

endpackage : debounce_pkg

// File: rtl/debounce_channel.sv
`timescale 1ns/100ps
// debounce_channel: one input's two-flop synchroniser, stability counter,
// debounced level and registered rise/fall strobes.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int STABLE_TICKS = 8
) (
  input  logic clk,
  input  logic nReset,
  input  logic tick_i,
  input  logic raw_i,
  output logic out_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int            CW   = cnt_width(STABLE_TICKS);
  localparam logic [CW-1:0] LAST = CW'(STABLE_TICKS - 1);

  logic          s1_q, s2_q;
  logic          out_q, out_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Next-state: a bounce back to the current level cancels progress at once;
  // otherwise progress only advances on a tick, and the last tick commits.
  always_comb begin
    out_d  = out_q;
    cnt_d  = cnt_q;
    rise_d = 1'b0;
    fall_d = 1'b0;
    if (s2_q == out_q) begin
      cnt_d = '0;
    end else if (!tick_i) begin
      cnt_d = cnt_q;
    end else if (cnt_q == LAST) begin
      out_d  = s2_q;
      cnt_d  = '0;
      rise_d = s2_q;
      fall_d = ~s2_q;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // State registers: synchroniser, counter, debounced level and strobes.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      out_q  <= 1'b0;
      cnt_q  <= '0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      s1_q   <= raw_i;
      s2_q   <= s1_q;
      out_q  <= out_d;
      cnt_q  <= cnt_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign out_o  = out_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule : debounce_channel

// File: rtl/debounce_bank.sv
`timescale 1ns/100ps
// debounce_bank: CHANNELS independent debouncers sharing one prescaler tick.
module debounce_bank
  import debounce_pkg::*;
#(
  parameter int CHANNELS     = 4,
  parameter int STABLE_TICKS = 8,
  parameter int TICK_DIV     = 1
) (
  input  logic                clk,
  input  logic                nReset,
  input  logic [CHANNELS-1:0] in,
  output logic [CHANNELS-1:0] out,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall
);

  // Reject parameter sets the channel logic cannot represent.
  if (CHANNELS < 1 || CHANNELS > MAX_CHANNELS) begin : g_bad_channels
    $fatal(1, "debounce_bank: CHANNELS must be 1..32");
  end
  if (STABLE_TICKS < 1) begin : g_bad_stable
    $fatal(1, "debounce_bank: STABLE_TICKS must be >= 1");
  end
  if (TICK_DIV < 1) begin : g_bad_div
    $fatal(1, "debounce_bank: TICK_DIV must be >= 1");
  end

  logic tick_s;

  if (TICK_DIV == 1) begin : g_no_prescale
    // Every clock is a tick; no counter is needed.
    assign tick_s = 1'b1;
  end else begin : g_prescale
    localparam int            PW    = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PLAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] pcnt_q, pcnt_d;

    // Prescaler next-state: count 0..TICK_DIV-1 and wrap.
    always_comb begin
      if (pcnt_q == PLAST) begin
        pcnt_d = '0;
      end else begin
        pcnt_d = pcnt_q + PW'(1);
      end
    end

    // Prescaler register.
    always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
        pcnt_q <= '0;
      end else begin
        pcnt_q <= pcnt_d;
      end
    end

    assign tick_s = (pcnt_q == PLAST);
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    debounce_channel #(
      .STABLE_TICKS(STABLE_TICKS)
    ) u_ch (
      .clk   (clk),
      .nReset(nReset),
      .tick_i(tick_s),
      .raw_i (in[i]),
      .out_o (out[i]),
      .rise_o(rise[i]),
      .fall_o(fall[i])
    );
  end

endmodule : debounce_bank

// File: tb/tb_debounce_bank.sv
`timescale 1ns/100ps
// tb_debounce_bank: scenario tasks plus a sliding-window reference model.
module tb_debounce_bank;

  localparam int ST = 8;

  logic       clk, nReset;
  logic [3:0] in_a, out_a, rise_a, fall_a;
  logic [3:0] in_b, out_b, rise_b, fall_b;
  int         checks, errors;

  debounce_bank #(.CHANNELS(4), .STABLE_TICKS(8), .TICK_DIV(1)) u_dut_a (
    .clk(clk), .nReset(nReset), .in(in_a), .out(out_a), .rise(rise_a), .fall(fall_a));

  debounce_bank #(.CHANNELS(4), .STABLE_TICKS(3), .TICK_DIV(4)) u_dut_b (
    .clk(clk), .nReset(nReset), .in(in_b), .out(out_b), .rise(rise_b), .fall(fall_b));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model for DUT A: hist[j] is the raw input sampled j+1 edges ago.
  // The synchronised level seen at an edge is the input from two edges back,
  // so an output flips once the last ST synchronised samples all differ from it.
  logic [3:0] hist [0:ST];
  logic [3:0] m_out, m_rise, m_fall, m_commit;

  always_comb begin
    m_commit = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      m_commit[i] = 1'b1;
      for (int j = 1; j <= ST; j++) begin
        if (hist[j][i] == m_out[i]) m_commit[i] = 1'b0;
      end
    end
  end

  always @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      for (int j = 0; j <= ST; j++) hist[j] <= 4'b0000;
      m_out  <= 4'b0000;
      m_rise <= 4'b0000;
      m_fall <= 4'b0000;
    end else begin
      hist[0] <= in_a;
      for (int j = 1; j <= ST; j++) hist[j] <= hist[j-1];
      m_out  <= m_out ^ m_commit;
      m_rise <= m_commit & ~m_out;
      m_fall <= m_commit & m_out;
    end
  end

  task automatic test_reset();
    in_a = 4'b1111;
    in_b = 4'b0000;
    nReset = 1'b1;
    #2 nReset = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      checks++;
      if ({out_a, rise_a, fall_a, out_b, rise_b, fall_b} !== 24'h000000) begin
        errors++;
        $display("FAIL reset_hold: out/rise/fall=%b/%b/%b required 0000/0000/0000", out_a, rise_a, fall_a);
      end
    end
    nReset = 1'b1;
    for (int k = 0; k < 13; k++) begin
      @(posedge clk); #1;
      checks++;
      if (out_a !== ((k >= 9) ? 4'b1111 : 4'b0000) || rise_a !== ((k == 9) ? 4'b1111 : 4'b0000) || fall_a !== 4'b0000) begin
        errors++;
        $display("FAIL reset_release edge %0d: out/rise/fall=%b/%b/%b", k, out_a, rise_a, fall_a);
      end
      checks++;
      if ({out_a, rise_a, fall_a} !== {m_out, m_rise, m_fall}) begin
        errors++;
        $display("FAIL model_reset edge %0d: got %b/%b/%b required %b/%b/%b", k, out_a, rise_a, fall_a, m_out, m_rise, m_fall);
      end
    end
  endtask

  task automatic test_release();
    int falls;
    in_a[2] = 1'b0;
    repeat (7) @(posedge clk);
    #1 in_a[2] = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      checks++;
      if (out_a[2] !== 1'b1 || fall_a[2] !== 1'b0 || {out_a, rise_a, fall_a} !== {m_out, m_rise, m_fall}) begin
        errors++;
        $display("FAIL release_short cyc %0d: out/fall=%b/%b required %b/%b (out[2]=1, no fall)", k, out_a, fall_a, m_out, m_fall);
      end
    end
    in_a[2] = 1'b0;
    falls = 0;
    for (int k = 0; k < 14; k++) begin
      @(posedge clk); #1;
      if (fall_a[2] === 1'b1) falls++;
      checks++;
      if ({out_a, rise_a, fall_a} !== {m_out, m_rise, m_fall}) begin
        errors++;
        $display("FAIL model_release cyc %0d: got %b/%b/%b required %b/%b/%b", k, out_a, rise_a, fall_a, m_out, m_rise, m_fall);
      end
    end
    checks++;
    if (out_a[2] !== 1'b0 || falls != 1) begin
      errors++;
      $display("FAIL release_long: out[2]=%b falls=%0d required 0 and 1", out_a[2], falls);
    end
    in_a[2] = 1'b1;
    repeat (12) @(posedge clk);
    #1;
  endtask

  task automatic test_all_low();
    in_a = 4'b0000;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      checks++;
      if ({out_a, rise_a, fall_a} !== {m_out, m_rise, m_fall}) begin
        errors++;
        $display("FAIL model_low cyc %0d: got %b/%b/%b required %b/%b/%b", k, out_a, rise_a, fall_a, m_out, m_rise, m_fall);
      end
    end
    checks++;
    if (out_a !== 4'b0000) begin
      errors++;
      $display("FAIL all_low: out=%b required 0000", out_a);
    end
  endtask

  // Toggles in_a[0] 20 times with a 9-unit period, offset so no toggle meets a clock edge.
  task automatic bounce_ch0();
    #0.5;
    for (int t = 0; t < 20; t++) begin
      in_a[0] = ~in_a[0];
      #9;
    end
  endtask

  task automatic test_bounce();
    fork
      bounce_ch0();
      for (int k = 0; k < 18; k++) begin
        @(posedge clk); #1;
        checks++;
        if (out_a[0] !== 1'b0 || rise_a[0] !== 1'b0 || fall_a[0] !== 1'b0 || {out_a, rise_a, fall_a} !== {m_out, m_rise, m_fall}) begin
          errors++;
          $display("FAIL bounce cyc %0d: out/rise/fall=%b/%b/%b required %b/%b/%b", k, out_a, rise_a, fall_a, m_out, m_rise, m_fall);
        end
      end
    join
    in_a[0] = 1'b1;
    for (int k = 0; k < 14; k++) begin
      @(posedge clk); #1;
      checks++;
      if (out_a[0] !== (k >= 9) || rise_a[0] !== (k == 9) || fall_a[0] !== 1'b0) begin
        errors++;
        $display("FAIL bounce_hold edge %0d: out0/rise0=%b/%b required %b/%b", k, out_a[0], rise_a[0], (k >= 9), (k == 9));
      end
    end
  endtask

  task automatic test_independence();
    fork
      begin
        #0.5;
        in_a[1] = 1'b1;
        in_a[3] = 1'b1;
        #0.0;
      end
      bounce_ch0();
      for (int k = 0; k < 17; k++) begin
        @(posedge clk); #1;
        checks++;
        if (rise_a !== ((k == 9) ? 4'b1010 : 4'b0000) || out_a[0] !== 1'b0 || {out_a, rise_a, fall_a} !== {m_out, m_rise, m_fall}) begin
          errors++;
          $display("FAIL independence edge %0d: out/rise=%b/%b required %b/%b", k, out_a, rise_a, m_out, (k == 9) ? 4'b1010 : 4'b0000);
        end
      end
    join
  endtask

  task automatic test_reset_mid();
    in_a[1] = 1'b1;
    for (int k = 0; k < 7; k++) begin
      @(posedge clk); #1;
      checks++;
      if (out_a !== 4'b0000) begin
        errors++;
        $display("FAIL reset_mid_count edge %0d: out=%b required 0000", k, out_a);
      end
    end
    #1 nReset = 1'b0;
    #1;
    checks++;
    if ({out_a, rise_a, fall_a} !== 12'h000) begin
      errors++;
      $display("FAIL reset_mid_assert: out/rise/fall=%b/%b/%b required 0", out_a, rise_a, fall_a);
    end
    #1 nReset = 1'b1;
    for (int k = 0; k < 13; k++) begin
      @(posedge clk); #1;
      checks++;
      if (out_a !== ((k >= 9) ? 4'b0010 : 4'b0000) || rise_a !== ((k == 9) ? 4'b0010 : 4'b0000) || {out_a, rise_a, fall_a} !== {m_out, m_rise, m_fall}) begin
        errors++;
        $display("FAIL reset_mid_requal edge %0d: out/rise=%b/%b required %b/%b", k, out_a, rise_a, m_out, m_rise);
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 600; k++) begin
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(0, 9) == 0) in_a[i] = ~in_a[i];
      end
      @(posedge clk); #1;
      checks++;
      if ({out_a, rise_a, fall_a} !== {m_out, m_rise, m_fall}) begin
        errors++;
        $display("FAIL random cyc %0d: got %b/%b/%b required %b/%b/%b", k, out_a, rise_a, fall_a, m_out, m_rise, m_fall);
      end
    end
  endtask

  task automatic test_prescaler();
    logic prev;
    int   ck;
    for (int t = 0; t < 6; t++) begin
      repeat ($urandom_range(1, 8)) @(posedge clk);
      #1;
      prev = out_b[0];
      in_b[0] = ~in_b[0];
      ck = -1;
      for (int k = 0; k < 20; k++) begin
        @(posedge clk); #1;
        checks++;
        if (ck < 0 && out_b[0] !== prev) begin
          ck = k;
          if (rise_b[0] !== ~prev || fall_b[0] !== prev) begin
            errors++;
            $display("FAIL prescaler_strobe trial %0d: rise/fall=%b/%b required %b/%b", t, rise_b[0], fall_b[0], ~prev, prev);
          end
        end else if (rise_b[0] !== 1'b0 || fall_b[0] !== 1'b0 || (ck >= 0 && out_b[0] !== ~prev)) begin
          errors++;
          $display("FAIL prescaler_width trial %0d cyc %0d: out/rise/fall=%b/%b/%b", t, k, out_b[0], rise_b[0], fall_b[0]);
        end
      end
      checks++;
      if (ck < 0 || (ck - 1) < 9 || (ck - 1) > 12) begin
        errors++;
        $display("FAIL prescaler_latency trial %0d: %0d cycles after s2 change required 9..12 (-2 means none)", t, ck - 1);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_release();
    test_all_low();
    test_bounce();
    test_all_low();
    test_independence();
    test_all_low();
    test_reset_mid();
    test_random();
    test_prescaler();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_debounce_bank
